// File: rtl/alu_cmd_sequencer_pkg.sv
// rtl/alu_cmd_sequencer_pkg.sv - shared types and constants for the ALU command sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_A   = 3'd1,
    LOAD_A  = 3'd2,
    GET_B   = 3'd3,
    EXEC    = 3'd4,
    SEND_LO = 3'd5,
    SEND_HI = 3'd6
  } seq_state_t;

  // Header byte layout: [2:0] op, [4:3] flagctl, [7:5] reserved
  localparam int OP_LSB   = 0;
  localparam int FLAG_LSB = 3;
  localparam int RSVD_LSB = 5;

  localparam int LAT_MAX = 7;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - byte-wide command and response streams of the sequencer
interface alu_cmd_sequencer_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/alu_cmd_sequencer_lat_counter.sv
// rtl/alu_cmd_sequencer_lat_counter.sv - 3-bit load/decrement counter timing result capture
module alu_seq_lat_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [2:0] cnt_q;

  // done marks the final counted cycle, so capture lands on cycle N of N
  assign done = dec && (cnt_q == 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_q <= cnt_q - 3'd1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - packs a 3-byte command onto the ALU pins and returns a 2-byte result
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int RESULT_LAT  = 1,
  parameter bit ERR_ON_RSVD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_sequencer_if.slave s,
  output logic [7:0]        alu_operand,
  output logic              alu_en_a,
  output logic [2:0]        alu_op,
  output logic [1:0]        alu_flagctl,
  input  logic [13:0]       alu_result,
  input  logic              alu_flag,
  input  logic              alu_ovf,
  output logic              busy,
  output logic              err,
  output logic [7:0]        cmd_count
);

  localparam logic [2:0] LAT_LOAD =
    (RESULT_LAT < 1 || RESULT_LAT > LAT_MAX) ? 3'(LAT_MAX) : 3'(RESULT_LAT);

  seq_state_t  state_q, state_d;
  logic [2:0]  op_q;
  logic [1:0]  flagctl_q;
  logic [7:0]  a_q, b_q;
  logic [15:0] res_q;
  logic        err_q;
  logic [7:0]  count_q;

  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic        lat_load, lat_dec, lat_done;
  logic        in_fire, out_fire, rsvd_bad;

  assign in_fire  = s.in_valid && in_ready;
  assign out_fire = out_valid && s.out_ready;
  assign rsvd_bad = ERR_ON_RSVD && (|s.in_data[7:RSVD_LSB]);

  alu_seq_lat_counter u_lat (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lat_load),
    .load_val (LAT_LOAD),
    .dec      (lat_dec),
    .done     (lat_done)
  );

  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = 8'h00;
    alu_operand = 8'h00;
    alu_en_a    = 1'b0;
    lat_load    = 1'b0;
    lat_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_fire && !rsvd_bad) state_d = GET_A;
      end
      GET_A: begin
        in_ready = 1'b1;
        if (in_fire) state_d = LOAD_A;
      end
      LOAD_A: begin
        alu_operand = a_q;
        alu_en_a    = 1'b1;
        state_d     = GET_B;
      end
      GET_B: begin
        in_ready = 1'b1;
        if (in_fire) begin
          lat_load = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        alu_operand = b_q;
        lat_dec     = 1'b1;
        if (lat_done) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = res_q[7:0];
        if (out_fire) state_d = SEND_HI;
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = res_q[15:8];
        if (out_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 3'd0;
      flagctl_q <= 2'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
      res_q     <= 16'h0000;
      err_q     <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      // A rejected header leaves op/flagctl untouched so the ALU pins stay quiet
      if (state_q == IDLE && in_fire) begin
        if (rsvd_bad) begin
          err_q <= 1'b1;
        end else begin
          op_q      <= s.in_data[OP_LSB +: 3];
          flagctl_q <= s.in_data[FLAG_LSB +: 2];
          err_q     <= 1'b0;
        end
      end
      if (state_q == GET_A && in_fire) a_q <= s.in_data;
      if (state_q == GET_B && in_fire) b_q <= s.in_data;
      if (state_q == EXEC && lat_done) res_q <= {alu_ovf, alu_flag, alu_result};
      if (state_q == SEND_HI && out_fire) count_q <= count_q + 8'd1;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid;
  assign s.out_data  = out_data;
  assign alu_op      = op_q;
  assign alu_flagctl = flagctl_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign cmd_count   = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer
module tb_alu_cmd_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  alu_operand;
  logic        alu_en_a;
  logic [2:0]  alu_op;
  logic [1:0]  alu_flagctl;
  logic [13:0] alu_result;
  logic        alu_flag, alu_ovf;
  logic        busy, err;
  logic [7:0]  cmd_count;

  alu_cmd_sequencer_if bus ();

  alu_cmd_sequencer #(.RESULT_LAT(LAT), .ERR_ON_RSVD(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (bus),
    .alu_operand (alu_operand),
    .alu_en_a    (alu_en_a),
    .alu_op      (alu_op),
    .alu_flagctl (alu_flagctl),
    .alu_result  (alu_result),
    .alu_flag    (alu_flag),
    .alu_ovf     (alu_ovf),
    .busy        (busy),
    .err         (err),
    .cmd_count   (cmd_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  h, a, b;
    logic [13:0] r;
    logic        f, o;
    logic [7:0]  lo, hi;
  } vec_t;

  vec_t       tbl [4];
  logic [7:0] sb [$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         en_count = 0;
  logic [7:0] last_a = 8'h00;
  logic [7:0] exp_count = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  // Response scoreboard and A-load pulse monitor, sampled 1 unit after negedge
  initial forever begin
    @(negedge clk);
    #1;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) check("unexpected_out_byte", {24'h0, bus.out_data}, 32'hFFFF_FFFF);
      else check("out_data", bus.out_data, sb.pop_front());
    end
    if (alu_en_a) begin
      en_count++;
      last_a = alu_operand;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_timeout", n < 50, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic issue(input logic [7:0] h, a, b, input logic [13:0] r, input logic f, o,
                       input logic [7:0] lo, hi, input bit chk);
    sb.push_back(lo);
    sb.push_back(hi);
    send_byte(h);
    send_byte(a);
    send_byte(b);
    // Only the last EXEC cycle carries the real result; the others carry decoys
    for (int i = 1; i <= LAT; i++) begin
      if (i == LAT) begin
        alu_result = r; alu_flag = f; alu_ovf = o;
      end else begin
        alu_result = r ^ 14'(i * 1297); alu_flag = ~f; alu_ovf = ~o;
      end
      if (chk) begin
        check("exec_alu_op", alu_op, h[2:0]);
        check("exec_flagctl", alu_flagctl, h[4:3]);
        check("exec_operand_b", alu_operand, b);
        check("exec_out_valid_low", bus.out_valid, 0);
      end
      @(negedge clk);
    end
    alu_result = r ^ 14'h1555; alu_flag = ~f; alu_ovf = ~o;
    if (chk) check("latency_out_valid", bus.out_valid, 1);
  endtask

  task automatic wait_resp();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("resp_timeout", sb.size() == 0, 1);
    sb.delete();
  endtask

  task automatic cmd(input logic [7:0] h, a, b, input logic [13:0] r, input logic f, o,
                     input logic [7:0] lo, hi, input bit chk);
    int en0 = en_count;
    issue(h, a, b, r, f, o, lo, hi, chk);
    wait_resp();
    exp_count++;
    if (chk) begin
      check("en_a_pulses", en_count - en0, 1);
      check("en_a_operand", last_a, a);
      check("busy_after", busy, 0);
      check("cmd_count", cmd_count, exp_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [13:0] r;
    logic [7:0]  h, a, b;
    logic        f, o;
    int          en0;

    tbl[0] = '{8'h00, 8'h80, 8'hDA, 14'h015A, 1'b0, 1'b1, 8'h5A, 8'h81};
    tbl[1] = '{8'h1B, 8'h12, 8'h34, 14'h3FFF, 1'b1, 1'b0, 8'hFF, 8'h7F};
    tbl[2] = '{8'h05, 8'hFF, 8'h01, 14'h2000, 1'b0, 1'b0, 8'h00, 8'h20};
    tbl[3] = '{8'h16, 8'h00, 8'h00, 14'h0000, 1'b1, 1'b1, 8'h00, 8'hC0};

    rst_n = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    alu_result = 14'h0; alu_flag = 1'b0; alu_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_alu_operand", alu_operand, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i])
      cmd(tbl[i].h, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f, tbl[i].o, tbl[i].lo, tbl[i].hi, 1'b1);

    // Reserved header bits set
    en0 = en_count;
    send_byte(8'hE0);
    check("rsvd_err", err, 1);
    check("rsvd_busy", busy, 0);
    check("rsvd_operand", alu_operand, 0);
    check("rsvd_no_load", en_count - en0, 0);
    cmd(8'h01, 8'h11, 8'h22, 14'h0ABC, 1'b1, 1'b0, 8'hBC, 8'h4A, 1'b1);
    check("rsvd_err_cleared", err, 0);

    // Back-pressure on the low response byte
    bus.out_ready = 1'b0;
    issue(8'h07, 8'h3C, 8'hC3, 14'h1234, 1'b0, 1'b1, 8'h34, 8'h92, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, 8'h34);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    wait_resp();
    exp_count++;
    check("bp_cmd_count", cmd_count, exp_count);

    // Counter wrap over 256 commands from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_count = 8'h00;
    for (int i = 0; i < 256; i++) begin
      h = {3'b000, 5'($urandom)};
      a = 8'($urandom); b = 8'($urandom);
      r = 14'($urandom); f = 1'($urandom); o = 1'($urandom);
      cmd(h, a, b, r, f, o, r[7:0], {o, f, r[13:8]}, 1'b0);
      if (i == 254) check("count_255", cmd_count, 8'd255);
    end
    check("count_wrap", cmd_count, 8'd0);

    // Reset during EXEC discards the command
    send_byte(8'h02);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_operand", alu_operand, 0);
    check("abort_en_a", alu_en_a, 0);
    check("abort_alu_op", alu_op, 0);
    check("abort_flagctl", alu_flagctl, 0);
    check("abort_cmd_count", cmd_count, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 8'h00;
    @(negedge clk);
    cmd(8'h0A, 8'h99, 8'h77, 14'h2468, 1'b1, 1'b1, 8'h68, 8'hE4, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
